id_stage_pipe: RTL and testbench

Parametrised, pipelined instruction-decode stage for the RSA decryption ASIP. It sits between the fetch stage and the execute stage. It holds the register file with a write-back bypass, and decodes the opcode, function, operand selectors and immediate extension internally instead of taking them as control inputs. Its output is a registered ID/EX pipeline slot with valid/ready handshakes on both sides, flush support and load-use hazard stalling.

---
 rtl/id_pkg.sv | 53 +++++
 rtl/id_regfile.sv | 42 ++++
 rtl/id_stage_pipe.sv | 128 ++++++++++++
 tb/tb_id_stage_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types and instruction field positions for the ID stage.
// Used by id_regfile and id_stage_pipe.
package id_pkg;

    typedef enum logic [2:0] {
        OP_ALU = 3'b000,
        OP_CMP = 3'b001,
        OP_LDR = 3'b010,
        OP_STR = 3'b011,
        OP_JEQ = 3'b100,
        OP_JNE = 3'b101,
        OP_JMP = 3'b110,
        OP_RSV = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        EXT_ALU,
        EXT_MEM,
        EXT_BR,
        EXT_NONE
    } ext_mode_e;

    localparam int unsigned OpMsb     = 31;
    localparam int unsigned OpLsb     = 29;
    localparam int unsigned RdMsb     = 27;
    localparam int unsigned RdLsb     = 24;
    localparam int unsigned RnMsb     = 22;
    localparam int unsigned RnLsb     = 19;
    localparam int unsigned RmMsb     = 17;
    localparam int unsigned RmLsb     = 14;
    localparam int unsigned ImmAluMsb = 13;
    localparam int unsigned ImmAluLsb = 2;
    localparam int unsigned ImmMemMsb = 14;
    localparam int unsigned ImmBrMsb  = 28;

    // Control half of the ID/EX slot; operand data is kept beside it since it is WIDTH-sized.
    typedef struct packed {
        logic       valid;
        opcode_e    op;
        logic [1:0] func;
        logic [3:0] rd;
    } id_ctrl_t;

    function automatic ext_mode_e ext_mode(opcode_e op);
        unique case (op)
            OP_ALU, OP_CMP:         return EXT_ALU;
            OP_LDR, OP_STR:         return EXT_MEM;
            OP_JEQ, OP_JNE, OP_JMP: return EXT_BR;
            default:                return EXT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// NREGS x WIDTH register file: synchronous write and clear, two combinational
// read ports with same-cycle write-back bypass.
module id_regfile
    import id_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [3:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [3:0]       raddr_a_i,
    input  logic [3:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    localparam int unsigned AddrW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [AddrW-1:0] waddr, raddr_a, raddr_b;

    assign waddr   = waddr_i[AddrW-1:0];
    assign raddr_a = raddr_a_i[AddrW-1:0];
    assign raddr_b = raddr_b_i[AddrW-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr] <= wdata_i;
        end
    end

    assign rdata_a_o = (we_i && raddr_a == waddr) ? wdata_i : regs_q[raddr_a];
    assign rdata_b_o = (we_i && raddr_b == waddr) ? wdata_i : regs_q[raddr_b];

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: register file, field decode, immediate extension and
// the registered ID/EX slot. Define ID_HAZARD_EN to enable load-use stalling.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic             flush,
    input  logic             wb_we,
    input  logic [3:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       op,
    output logic [1:0]       func,
    output logic [3:0]       rd,
    output logic [WIDTH-1:0] rda,
    output logic [WIDTH-1:0] rdb,
    output logic [WIDTH-1:0] extended
);

    opcode_e          op_in;
    logic [3:0]       rd_field, rn_in, portb_addr, rd_dec;
    logic [WIDTH-1:0] rf_a, rf_b, ext_in;
    logic             hz;

    id_ctrl_t         ctrl_q, ctrl_d;
    logic [WIDTH-1:0] rda_q, rda_d, rdb_q, rdb_d, ext_q, ext_d;

    assign op_in      = opcode_e'(instruction[OpMsb:OpLsb]);
    assign rd_field   = instruction[RdMsb:RdLsb];
    assign rn_in      = instruction[RnMsb:RnLsb];
    // Stores read their data register through port B.
    assign portb_addr = (op_in == OP_STR) ? rd_field : instruction[RmMsb:RmLsb];
    assign rd_dec     = (op_in == OP_RSV) ? 4'd0 : rd_field;

    always_comb begin
        ext_in = '0;
        unique case (ext_mode(op_in))
            EXT_ALU:  ext_in = WIDTH'(instruction[ImmAluMsb:ImmAluLsb]);
            EXT_MEM:  ext_in = WIDTH'(instruction[ImmMemMsb:0]);
            EXT_BR:   ext_in = {{(WIDTH-ImmBrMsb-1){instruction[ImmBrMsb]}},
                                instruction[ImmBrMsb:0]};
            default:  ext_in = '0;
        endcase
    end

    id_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (wb_we),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rn_in),
        .raddr_b_i (portb_addr),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

`ifdef ID_HAZARD_EN
    logic uses_b;
    assign uses_b = (((op_in == OP_ALU) || (op_in == OP_CMP)) && !instruction[0]) ||
                    (op_in == OP_STR);
    assign hz = ctrl_q.valid && (ctrl_q.op == OP_LDR) &&
                ((ctrl_q.rd == rn_in) || (uses_b && (ctrl_q.rd == portb_addr)));
`else
    assign hz = 1'b0;
`endif

    assign in_ready = reset && !flush && !hz && (!ctrl_q.valid || out_ready);

    always_comb begin
        ctrl_d = ctrl_q;
        rda_d  = rda_q;
        rdb_d  = rdb_q;
        ext_d  = ext_q;
        if (flush) begin
            ctrl_d.valid = 1'b0;
        end else if (in_valid && in_ready) begin
            ctrl_d.valid = 1'b1;
            ctrl_d.op    = op_in;
            ctrl_d.func  = instruction[1:0];
            ctrl_d.rd    = rd_dec;
            rda_d        = rf_a;
            rdb_d        = rf_b;
            ext_d        = ext_in;
        end else if (hz && out_ready) begin
            ctrl_d = '0;
            rda_d  = '0;
            rdb_d  = '0;
            ext_d  = '0;
        end else if (out_ready) begin
            ctrl_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q <= '0;
            rda_q  <= '0;
            rdb_q  <= '0;
            ext_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rda_q  <= rda_d;
            rdb_q  <= rdb_d;
            ext_q  <= ext_d;
        end
    end

    assign out_valid = ctrl_q.valid;
    assign op        = ctrl_q.op;
    assign func      = ctrl_q.func;
    assign rd        = ctrl_q.rd;
    assign rda       = rda_q;
    assign rdb       = rdb_q;
    assign extended  = ext_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table plus hazard, back-pressure,
// flush and mid-operation reset sequences. Follows ID_HAZARD_EN like the RTL.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, wb_we, out_valid, out_ready;
    logic [31:0] instruction, wb_data, rda, rdb, extended;
    logic [3:0]  wb_addr, rd;
    logic [2:0]  op;
    logic [1:0]  func;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(
        .WIDTH (32),
        .NREGS (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op          (op),
        .func        (func),
        .rd          (rd),
        .rda         (rda),
        .rdb         (rdb),
        .extended    (extended)
    );

    typedef struct {
        logic [31:0] instr;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [2:0]  op;
        logic [1:0]  func;
        logic [3:0]  rd;
        logic [31:0] rda;
        logic [31:0] rdb;
        logic [31:0] ext;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        dep;
    } hz_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d);
        in_valid = 1'b0;
        wb_we    = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        step();
        wb_we    = 1'b0;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [2:0] o,
                            input logic [1:0] f, input logic [3:0] r,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".op"}, 32'(op), 32'(o));
        chk({tag, ".func"}, 32'(func), 32'(f));
        chk({tag, ".rd"}, 32'(rd), 32'(r));
        chk({tag, ".rda"}, rda, a);
        chk({tag, ".rdb"}, rdb, b);
        chk({tag, ".ext"}, extended, e);
    endtask

    vec_t vecs[8];
    hz_t  hzv[6];
    logic hz_on;

    initial begin
`ifdef ID_HAZARD_EN
        hz_on = 1'b1;
`else
        hz_on = 1'b0;
`endif
        vecs[0] = '{32'h00088000, 1'b0, 4'd0,  32'h0,    3'd0, 2'b00, 4'd0,
                    32'd1,     32'd2,     32'd0};
        vecs[1] = '{32'h01100029, 1'b1, 4'd2,  32'd7,    3'd0, 2'b01, 4'd1,
                    32'd7,     32'd0,     32'd10};
        vecs[2] = '{32'h20197FFE, 1'b0, 4'd0,  32'h0,    3'd1, 2'b10, 4'd0,
                    32'h333,   32'h55,    32'hFFF};
        vecs[3] = '{32'h43487FFF, 1'b0, 4'd0,  32'h0,    3'd2, 2'b11, 4'd3,
                    32'h99,    32'd1,     32'h7FFF};
        vecs[4] = '{32'h66380020, 1'b0, 4'd0,  32'h0,    3'd3, 2'b00, 4'd6,
                    32'h77,    32'h66,    32'h20};
        vecs[5] = '{32'h9FFFFFF0, 1'b1, 4'd15, 32'hABCD, 3'd4, 2'b00, 4'd15,
                    32'hABCD,  32'hABCD,  32'hFFFFFFF0};
        vecs[6] = '{32'hC0000123, 1'b1, 4'd0,  32'h1234, 3'd6, 2'b11, 4'd0,
                    32'h1234,  32'h1234,  32'h123};
        vecs[7] = '{32'hEA080001, 1'b0, 4'd0,  32'h0,    3'd7, 2'b01, 4'd0,
                    32'd1,     32'h1234,  32'd0};

        // Each follows LDR R5: dep marks a load-use hazard against R5.
        hzv[0] = '{32'h01280000, 1'b1};
        hzv[1] = '{32'h01014000, 1'b1};
        hzv[2] = '{32'h01014001, 1'b0};
        hzv[3] = '{32'h65000000, 1'b1};
        hzv[4] = '{32'h21014001, 1'b0};
        hzv[5] = '{32'h85280000, 1'b1};

        reset       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        flush       = 1'b0;
        wb_we       = 1'b0;
        wb_addr     = 4'd0;
        wb_data     = 32'h0;
        out_ready   = 1'b1;
        step();
        step();
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk_slot("rst", 1'b0, 3'd0, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0);
        reset = 1'b1;

        for (int r = 0; r < 16; r++) begin
            instruction = (32'(r) << 19) | (32'(r) << 14);
            in_valid    = 1'b1;
            step();
            chk($sformatf("rf0.r%0d.a", r), rda, 32'd0);
            chk($sformatf("rf0.r%0d.b", r), rdb, 32'd0);
        end

        wb(4'd1, 32'd1);
        wb(4'd2, 32'd2);
        wb(4'd3, 32'h333);
        wb(4'd5, 32'h55);
        wb(4'd6, 32'h66);
        wb(4'd7, 32'h77);
        wb(4'd9, 32'h99);

        for (int i = 0; i < 8; i++) begin
            in_valid    = 1'b1;
            instruction = vecs[i].instr;
            wb_we       = vecs[i].we;
            wb_addr     = vecs[i].wa;
            wb_data     = vecs[i].wd;
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
            step();
            wb_we = 1'b0;
            chk_slot($sformatf("v%0d", i), 1'b1, vecs[i].op, vecs[i].func, vecs[i].rd,
                     vecs[i].rda, vecs[i].rdb, vecs[i].ext);
        end
        in_valid = 1'b0;
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Load-use: LDR R5 then ADD R1,R5,R0.
        in_valid    = 1'b1;
        instruction = 32'h45300020;
        step();
        chk("lu.ldr.op", 32'(op), 32'd2);
        chk("lu.ldr.rda", rda, 32'h66);
        instruction = 32'h01280000;
        #1;
        chk("lu.in_ready", 32'(in_ready), 32'(!hz_on));
        step();
        if (hz_on) begin
            chk("lu.bubble", 32'(out_valid), 32'd0);
            chk("lu.retry", 32'(in_ready), 32'd1);
            step();
        end
        chk("lu.add.valid", 32'(out_valid), 32'd1);
        chk("lu.add.rd", 32'(rd), 32'd1);
        chk("lu.add.rda", rda, 32'h55);
        in_valid = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            in_valid    = 1'b1;
            instruction = 32'h45300020;
            step();
            instruction = hzv[i].instr;
            #1;
            chk($sformatf("hz%0d.in_ready", i), 32'(in_ready), 32'(!(hz_on && hzv[i].dep)));
            in_valid = 1'b0;
            step();
            step();
        end

        // Back-pressure on STR R6,32(R7).
        in_valid    = 1'b1;
        instruction = 32'h66380020;
        step();
        instruction = 32'h00088000;
        out_ready   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'd0);
            step();
            chk_slot($sformatf("bp%0d", c), 1'b1, 3'd3, 2'b00, 4'd6, 32'h77, 32'h66, 32'h20);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp.release", 32'(out_valid), 32'd0);

        // Flush with a valid slot and a competing instruction.
        in_valid    = 1'b1;
        instruction = 32'h01100029;
        step();
        chk("fl.pre", 32'(out_valid), 32'd1);
        instruction = 32'hEA080001;
        flush       = 1'b1;
        out_ready   = 1'b0;
        #1;
        chk("fl.in_ready", 32'(in_ready), 32'd0);
        step();
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.op", 32'(op), 32'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl.after", 32'(out_valid), 32'd0);
        chk("fl.after.op", 32'(op), 32'd0);

        // Reset during back-pressure clears slot and register file.
        in_valid    = 1'b1;
        instruction = 32'h00088000;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        reset     = 1'b0;
        #1;
        chk("mr.in_ready", 32'(in_ready), 32'd0);
        step();
        chk_slot("mr", 1'b0, 3'd0, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        chk("mr.rf.rda", rda, 32'd0);
        chk("mr.rf.rdb", rdb, 32'd0);
        chk("mr.rf.valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
